frame_reader: RTL and testbench
===============================

// Module: frame_reader
// PURPOSE
//  Read side of the DDR frame buffers filled by the camera capture block. At each display
//  frame start, selects the most recently completed camera slot and issues 128-bit burst reads
//  at 4-address stride. Buffers returned words in a small FIFO and unpacks each into eight
//  16-bit RGB565 pixels for the display pipeline, one pixel per pix_req.
// PARAMETERS
//  WORDS_PER_FRAME  38400  128-bit words per frame (640x480x2 bytes / 16)
//  FIFO_DEPTH       8      word FIFO depth (power of 2)
//  NUM_SLOTS        6      frame slots in DDR, bases k*0x25800, k=0..NUM_SLOTS-1
// PORTS
//  clk            in   1    single clock; DDR user side and display share it
//  rst            in   1    asynchronous, active-high reset
//  last_frame     in   3    slot the camera is currently writing (0..NUM_SLOTS-1)
//  frame_start    in   1    1-cycle pulse: display begins a new frame
//  rd_req         out  1    read request; held until accepted by rd_ack
//  rd_address     out  25   word address of request (slot base + 4*word index)
//  rd_ack         in   1    request accepted this cycle (rd_req && rd_ack = handshake)
//  rd_data        in   128  returned word, in request order
//  rd_data_valid  in   1    rd_data valid this cycle
//  pix_req        in   1    display consumes one pixel this cycle
//  pixel          out  16   RGB565 pixel, valid with pixel_valid
//  pixel_valid    out  1    pixel holds the pixel for the current pix_req
//  underflow      out  1    sticky: pix_req seen while no pixel available; cleared by frame_start
// BEHAVIOUR
//  Reset: rd_req=0, rd_address=0, pixel=0, pixel_valid=0, underflow=0, FSM=IDLE, FIFO empty,
//   pending=0, discard=0, word index=0, pixel index=0.
//  Slot select on frame_start: rd_slot = (last_frame==0) ? NUM_SLOTS-1 : last_frame-1;
//   rd_address <= rd_slot*0x25800; word index <= 0.
//  FSM: IDLE -frame_start-> FETCH; FETCH -last word accepted-> DRAIN; DRAIN -frame_start-> FETCH.
//   frame_start in any state restarts at FETCH (highest priority).
//  FETCH: rd_req=1 only when fifo_count + pending < FIFO_DEPTH (credit rule, FIFO never
//   overflows). On rd_ack: rd_address += 4, word index++, pending++. rd_req drops the cycle
//   after the acceptance of word WORDS_PER_FRAME-1.
//  Return: rd_data_valid with discard>0 -> word dropped, discard--; else word pushed to FIFO,
//   pending--. Simultaneous ack and return: pending unchanged.
//  Restart mid-frame: FIFO flushed, pixel index=0, discard <= discard + pending, pending <= 0,
//   underflow cleared, pixel_valid=0. No pixel of the old frame appears after frame_start.
//  Unpack: pixel index k=0..7 within head word W; pixel = {W[16k+7:16k], W[16k+15:16k+8]}
//   (first byte received from camera is MSB). pix_req with FIFO non-empty: pixel/pixel_valid
//   registered next cycle (1-cycle latency), k++; after k=7 FIFO pops and k wraps to 0.
//  pix_req with FIFO empty: pixel_valid=0 next cycle, underflow<=1, k unchanged.
//  pix_req not asserted: pixel_valid=0, pixel holds last value.
//  Address arithmetic 25-bit; max address NUM_SLOTS*0x25800-4 = 0xE0FFC, no wrap within a frame.
// TESTING
//  1) last_frame=2, frame_start; memory model acks every cycle, returns 3 cycles later
//     -> first rd_address=0x25800, last=0x4AFFC, exactly 38400 requests, no underflow.
//  2) last_frame=0 at frame_start -> rd_address starts 0xBB800 (slot 5).
//  3) word 0x...0F0E_..._0302_0100, 8 back-to-back pix_req -> pixels 0x0001,0x0203,...,0x0E0F,
//     each one cycle after its pix_req.
//  4) Model stalls returns 20 cycles -> pending+count never exceeds 8; pix_req during stall
//     -> pixel_valid=0, underflow=1; next frame_start clears underflow.
//  5) frame_start with 5 reads pending -> 5 returns dropped, next pixel from new slot word 0.
//  6) Assert rst mid-FETCH (async, off-edge) -> rd_req and pixel_valid low immediately, IDLE.

Source files
------------

// File: rtl/frame_reader_if.sv
// frame_reader_if: bundles the DDR read-request/return bus and the display
// pixel bus of the frame reader.
//   master : the frame reader (drives rd_req/rd_address and the pixel outputs)
//   slave  : the environment (DDR controller user port, camera and display side)
// Signals:
//   last_frame    3    slot the camera is currently writing
//   frame_start   1    display frame start pulse
//   rd_req        1    read request, held until rd_ack
//   rd_address    25   word address of the request
//   rd_ack        1    request accepted this cycle
//   rd_data       128  returned word, in request order
//   rd_data_valid 1    rd_data valid this cycle
//   pix_req       1    display consumes one pixel
//   pixel         16   RGB565 pixel
//   pixel_valid   1    pixel answers the previous pix_req
//   underflow     1    sticky starvation flag
interface frame_reader_if;
  logic [2:0]   last_frame;
  logic         frame_start;
  logic         rd_req;
  logic [24:0]  rd_address;
  logic         rd_ack;
  logic [127:0] rd_data;
  logic         rd_data_valid;
  logic         pix_req;
  logic [15:0]  pixel;
  logic         pixel_valid;
  logic         underflow;

  modport master (
    input  last_frame, frame_start, rd_ack, rd_data, rd_data_valid, pix_req,
    output rd_req, rd_address, pixel, pixel_valid, underflow
  );

  modport slave (
    output last_frame, frame_start, rd_ack, rd_data, rd_data_valid, pix_req,
    input  rd_req, rd_address, pixel, pixel_valid, underflow
  );
endinterface

// File: rtl/frame_reader.sv
// frame_reader: read side of the DDR camera frame buffers.
// On each display frame_start it picks the most recently completed camera
// slot, streams that frame out of DDR as 128-bit reads at a 4-address stride,
// buffers returned words in a small FIFO and hands them to the display as
// RGB565 pixels, eight per word, one per pix_req with one cycle of latency.
// Ports:
//   clk  single clock shared by DDR user side and display
//   rst  asynchronous, active-high reset
//   bus  frame_reader_if.master (request bus, return bus, pixel bus)
module frame_reader #(
  parameter int WORDS_PER_FRAME = 38400,
  parameter int FIFO_DEPTH      = 8,
  parameter int NUM_SLOTS       = 6
) (
  input  logic           clk,
  input  logic           rst,
  frame_reader_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(WORDS_PER_FRAME);
  localparam logic [24:0]      SLOT_SIZE = 25'h25800;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_FRAME - 1);
  localparam logic [CNT_W:0]   DEPTH_V   = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t           state;
  logic [127:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pending;
  logic [7:0]       discard;
  logic [IDX_W-1:0] word_idx;
  logic [2:0]       pix_idx;

  // The slot being written is incomplete, so read the one before it.
  function automatic logic [24:0] slot_base(input logic [2:0] last);
    logic [2:0] slot;
    slot = (last == 3'd0) ? 3'(NUM_SLOTS - 1) : last - 3'd1;
    return 25'(slot) * SLOT_SIZE;
  endfunction

  // The camera's first byte of each pixel sits in the low byte lane.
  function automatic logic [15:0] unpack(input logic [127:0] word, input logic [2:0] idx);
    logic [15:0] half;
    half = word[16*idx +: 16];
    return {half[7:0], half[15:8]};
  endfunction

  logic             issued;
  logic             ret_drop;
  logic             push;
  logic             has_pix;
  logic             pop;
  logic             last_issue;
  logic [CNT_W-1:0] count_nx;
  logic [CNT_W-1:0] pending_nx;
  logic [CNT_W:0]   credit_use;

  assign issued     = bus.rd_req & bus.rd_ack;
  assign ret_drop   = bus.rd_data_valid & (discard != 8'd0);
  assign push       = bus.rd_data_valid & (discard == 8'd0);
  assign has_pix    = (count != '0);
  assign pop        = bus.pix_req & has_pix & (pix_idx == 3'd7);
  assign last_issue = issued & (word_idx == LAST_IDX);
  assign count_nx   = count + CNT_W'(push) - CNT_W'(pop);
  assign pending_nx = pending + CNT_W'(issued) - CNT_W'(push);
  // Words in the FIFO plus words still in flight: new requests only while
  // this stays below the FIFO depth, so every return has a slot waiting.
  assign credit_use = {1'b0, count_nx} + {1'b0, pending_nx};

  // Request, FIFO bookkeeping and pixel output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.rd_req      <= 1'b0;
      bus.rd_address  <= '0;
      word_idx        <= '0;
      pending         <= '0;
      discard         <= '0;
      count           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      pix_idx         <= '0;
      bus.pixel       <= '0;
      bus.pixel_valid <= 1'b0;
      bus.underflow   <= 1'b0;
    end else if (bus.frame_start) begin
      // Everything still in flight (including a request accepted or a word
      // returned this very cycle) belongs to the old frame and is discarded.
      state           <= FETCH;
      bus.rd_req      <= 1'b1;
      bus.rd_address  <= slot_base(bus.last_frame);
      word_idx        <= '0;
      discard         <= discard + 8'(pending) + 8'(issued) - 8'(bus.rd_data_valid);
      pending         <= '0;
      count           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      pix_idx         <= '0;
      bus.pixel_valid <= 1'b0;
      bus.underflow   <= 1'b0;
    end else begin
      if (issued) begin
        bus.rd_address <= bus.rd_address + 25'd4;
        word_idx       <= word_idx + IDX_W'(1);
      end
      case (state)
        FETCH: begin
          if (last_issue) begin
            state      <= DRAIN;
            bus.rd_req <= 1'b0;
          end else begin
            // An unaccepted request never loses its credit: the sum can only
            // shrink until the next acceptance.
            bus.rd_req <= (credit_use < DEPTH_V);
          end
        end
        default: bus.rd_req <= 1'b0;
      endcase

      pending <= pending_nx;
      discard <= discard - 8'(ret_drop);
      count   <= count_nx;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (bus.pix_req) begin
        if (has_pix) begin
          bus.pixel       <= unpack(mem[rd_ptr], pix_idx);
          bus.pixel_valid <= 1'b1;
          pix_idx         <= pix_idx + 3'd1;
        end else begin
          bus.pixel_valid <= 1'b0;
          bus.underflow   <= 1'b1;
        end
      end else begin
        bus.pixel_valid <= 1'b0;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rd_data;
  end
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: randomized self-checking bench for frame_reader.
// A memory model answers requests in order with configurable latency and
// stalls. The reference model tags every request with the display frame it
// was issued in; only words of the current frame reach the model FIFO, and
// each pix_req is answered from that FIFO one cycle later.
module tb_frame_reader;
  localparam int WPF   = 40;
  localparam int DEPTH = 8;
  localparam int SLOTS = 6;
  localparam logic [127:0] PATTERN = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_reader_if bus();

  frame_reader #(.WORDS_PER_FRAME(WPF), .FIFO_DEPTH(DEPTH), .NUM_SLOTS(SLOTS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0]  due;
    logic [24:0]  addr;
    logic [127:0] data;
    logic [31:0]  epoch;
  } rd_t;

  rd_t          ret_q[$];
  logic [127:0] fifo_q[$];
  int           epoch, issued_cur, outstanding_cur, pix_k, dropped;
  logic [24:0]  cur_base, first_addr, last_addr, prev_addr;
  logic         exp_pv, exp_und;
  logic [15:0]  exp_pix;
  int unsigned  cyc, last_due;
  int           checks, errors;
  int           ack_pct, pix_pct, lat_min, lat_max;
  bit           stall, pattern_mode, fs_req, prev_wait, prev_last;
  logic [2:0]   lf_req;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [24:0] exp_base(input int lf);
    int s;
    s = (lf == 0) ? SLOTS - 1 : lf - 1;
    return 25'(s * 'h25800);
  endfunction

  function automatic logic [15:0] pix_of(input logic [127:0] w, input int k);
    return {w[16*k +: 8], w[16*k+8 +: 8]};
  endfunction

  task automatic model_reset();
    ret_q.delete();
    fifo_q.delete();
    epoch++;
    pix_k = 0; exp_pv = 0; exp_und = 0; exp_pix = '0;
    issued_cur = 0; outstanding_cur = 0;
    prev_wait = 0; prev_last = 0;
    cur_base = '0; last_due = cyc;
  endtask

  task automatic cycle();
    rd_t r;
    bit  hs, ret, fs, pr;
    int  lat;
    @(negedge clk);
    cyc++;
    // outputs registered at the previous edge
    chk("pixel_valid", bus.pixel_valid, exp_pv);
    if (exp_pv) chk("pixel", bus.pixel, exp_pix);
    chk("underflow", bus.underflow, exp_und);
    if (prev_wait) begin
      chk("rd_req_hold", bus.rd_req, 1'b1);
      chk("rd_address_hold", bus.rd_address, prev_addr);
    end
    if (prev_last) chk("rd_req_drop", bus.rd_req, 1'b0);

    // inputs for the next edge
    fs = fs_req; fs_req = 0;
    bus.frame_start = fs;
    bus.last_frame  = lf_req;
    pr = ($urandom_range(99) < pix_pct);
    bus.pix_req = pr;
    bus.rd_ack  = ($urandom_range(99) < ack_pct);
    hs  = bus.rd_req && bus.rd_ack;
    ret = !stall && (ret_q.size() > 0) && (ret_q[0].due <= cyc);
    bus.rd_data_valid = ret;
    bus.rd_data = ret ? ret_q[0].data : {$urandom(), $urandom(), $urandom(), $urandom()};

    // model of what that edge does
    prev_wait = bus.rd_req && !bus.rd_ack && !fs;
    prev_addr = bus.rd_address;
    prev_last = 0;
    if (hs) begin
      chk("rd_address", bus.rd_address, cur_base + 25'(4 * issued_cur));
      chk("req_within_frame", (issued_cur < WPF), 1'b1);
      if (issued_cur == 0) first_addr = bus.rd_address;
      last_addr = bus.rd_address;
      lat = $urandom_range(lat_max, lat_min);
      r.due = cyc + lat;
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      r.addr  = bus.rd_address;
      r.data  = pattern_mode ? PATTERN : {$urandom(), $urandom(), $urandom(), $urandom()};
      r.epoch = epoch;
      ret_q.push_back(r);
      issued_cur++;
      outstanding_cur++;
      if (issued_cur == WPF && !fs) prev_last = 1;
    end
    if (!fs) begin
      if (pr) begin
        if (fifo_q.size() > 0) begin
          exp_pv  = 1;
          exp_pix = pix_of(fifo_q[0], pix_k);
          pix_k++;
          if (pix_k == 8) begin
            pix_k = 0;
            fifo_q.delete(0);
          end
        end else begin
          exp_pv  = 0;
          exp_und = 1;
        end
      end else begin
        exp_pv = 0;
      end
    end
    if (ret) begin
      r = ret_q.pop_front();
      if (!fs && r.epoch == epoch) begin
        fifo_q.push_back(r.data);
        outstanding_cur--;
      end else begin
        dropped++;
      end
    end
    if (fs) begin
      epoch++;
      fifo_q.delete();
      pix_k = 0; exp_pv = 0; exp_und = 0;
      cur_base = exp_base(lf_req);
      issued_cur = 0; outstanding_cur = 0;
    end
    if (hs && !fs) chk("credit", (fifo_q.size() + outstanding_cur <= DEPTH), 1'b1);
  endtask

  localparam logic [15:0] LIT_PIX [8] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607,
                                          16'h0809, 16'h0A0B, 16'h0C0D, 16'h0E0F};

  initial begin
    bus.frame_start = 0; bus.last_frame = 0; bus.rd_ack = 0;
    bus.rd_data = '0; bus.rd_data_valid = 0; bus.pix_req = 0;
    checks = 0; errors = 0; cyc = 0; epoch = 0; dropped = 0;
    ack_pct = 100; pix_pct = 0; lat_min = 3; lat_max = 3;
    stall = 0; pattern_mode = 0; fs_req = 0; lf_req = 0;
    first_addr = '0; last_addr = '0; prev_addr = '0;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_rd_req", bus.rd_req, 1'b0);
    chk("reset_rd_address", bus.rd_address, 25'h0);
    chk("reset_pixel", bus.pixel, 16'h0);
    chk("reset_pixel_valid", bus.pixel_valid, 1'b0);
    chk("reset_underflow", bus.underflow, 1'b0);
    rst = 0;

    // full frame from slot 1, returns 3 cycles after acceptance
    lf_req = 2; fs_req = 1; cycle();
    repeat (12) cycle();
    pix_pct = 50;
    for (int i = 0; i < 3000 && issued_cur < WPF; i++) cycle();
    chk("t1_request_count", issued_cur, WPF);
    chk("t1_first_address", first_addr, 25'h25800);
    chk("t1_last_address", last_addr, 25'h2589C);
    for (int i = 0; i < 3000 && (ret_q.size() > 0 || fifo_q.size() > 0); i++) cycle();
    chk("t1_drained", fifo_q.size() + ret_q.size(), 0);
    chk("t1_no_underflow", bus.underflow, 1'b0);

    // last_frame 0 wraps to the top slot
    pix_pct = 0; lf_req = 0; fs_req = 1; cycle();
    repeat (4) cycle();
    chk("t2_first_address", first_addr, 25'hBB800);

    // byte order of the unpacked pixels
    pattern_mode = 1; lf_req = 3; fs_req = 1; cycle();
    for (int i = 0; i < 100 && fifo_q.size() == 0; i++) cycle();
    chk("t3_word_arrived", (fifo_q.size() > 0), 1'b1);
    pix_pct = 100; cycle();
    for (int j = 0; j < 8; j++) begin
      if (j == 7) pix_pct = 0;
      cycle();
      chk("t3_pixel_valid", bus.pixel_valid, 1'b1);
      chk("t3_pixel", bus.pixel, LIT_PIX[j]);
    end
    pattern_mode = 0;

    // stalled returns: credit limit and underflow
    stall = 1; lf_req = 4; fs_req = 1; cycle();
    pix_pct = 100;
    repeat (20) cycle();
    chk("t4_requests_in_stall", issued_cur, DEPTH);
    chk("t4_underflow_set", bus.underflow, 1'b1);
    stall = 0; pix_pct = 0;
    repeat (30) cycle();
    lf_req = 5; fs_req = 1; cycle();
    cycle();
    chk("t4_underflow_cleared", bus.underflow, 1'b0);

    // restart with five reads in flight
    for (int i = 0; i < 500 && ret_q.size() > 0; i++) cycle();
    lat_min = 15; lat_max = 15;
    lf_req = 1; fs_req = 1; cycle();
    for (int i = 0; i < 100 && outstanding_cur < 5; i++) cycle();
    ack_pct = 0; dropped = 0; fs_req = 1; cycle();
    ack_pct = 100;
    repeat (40) cycle();
    chk("t5_dropped", dropped, 5);
    lat_min = 3; lat_max = 3; pix_pct = 40;
    repeat (150) cycle();
    chk("t5_first_address", first_addr, 25'h0);

    // asynchronous reset in the middle of a fetch
    pix_pct = 0; lf_req = 2; fs_req = 1; cycle();
    repeat (10) cycle();
    pix_pct = 100;
    for (int i = 0; i < 200 && !(bus.rd_req && bus.pixel_valid); i++) cycle();
    chk("t6_busy_before_reset", (bus.rd_req && bus.pixel_valid), 1'b1);
    #3 rst = 1;
    #1;
    chk("t6_rd_req_low", bus.rd_req, 1'b0);
    chk("t6_pixel_valid_low", bus.pixel_valid, 1'b0);
    chk("t6_rd_address_zero", bus.rd_address, 25'h0);
    pix_pct = 0;
    bus.pix_req = 0; bus.rd_ack = 0; bus.rd_data_valid = 0; bus.frame_start = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    repeat (10) cycle();
    chk("t6_idle_after_reset", bus.rd_req, 1'b0);

    // randomized traffic
    for (int seg = 0; seg < 15; seg++) begin
      ack_pct = $urandom_range(100, 30);
      pix_pct = $urandom_range(70, 5);
      lat_min = $urandom_range(4, 1);
      lat_max = lat_min + $urandom_range(6, 0);
      lf_req  = 3'($urandom_range(SLOTS - 1, 0));
      fs_req  = 1;
      for (int i = 0; i < 200; i++) begin
        if (i % 10 == 0) stall = ($urandom_range(7, 0) == 0);
        if ($urandom_range(149, 0) == 0) begin
          lf_req = 3'($urandom_range(SLOTS - 1, 0));
          fs_req = 1;
        end
        cycle();
      end
    end
    stall = 0;
    repeat (100) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
